store_queue: RTL and testbench
==============================

# store_queue

Committed-store buffer sitting directly downstream of the reorder-buffer commit stage: each store retired in program order is pushed here, and the block drains stores to data memory one at a time over a req/ack handshake. It decouples commit from memory latency. It also forwards the youngest pending store value to loads so that later loads see committed-but-unwritten data. Its `empty` output gates halt completion, so the CPU stops only after all stores reach memory.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- ADDR_W, 10, word-address width
- DATA_W, 32, data width
- clk  in  1  clock
- RSTN_N  in  1  reset, asynchronous, active-low
- commit_valid  in  1  commit stage presents a store this cycle
- commit_addr  in  ADDR_W  store word address
- commit_data  in  DATA_W  store data
- commit_ready  out  1  queue can accept a push (= !full)
- mem_req  out  1  write request to data memory
- mem_addr  out  ADDR_W  head entry address
- mem_wdata  out  DATA_W  head entry data
- mem_ack  in  1  memory accepted the write this cycle
- ld_addr  in  ADDR_W  load lookup address
- ld_hit  out  1  some pending entry matches ld_addr
- ld_data  out  DATA_W  data of youngest matching entry; 0 when !ld_hit
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Circular buffer; head/tail pointers $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count tracked separately (full = count==DEPTH).
- Push: on posedge with commit_valid && commit_ready, write {commit_addr, commit_data} at tail, tail+1, count+1. commit_valid while !commit_ready is ignored; commit stage must hold and retry.
- Drain FSM, two states:
  - IDLE: mem_req=0. Go to REQ when count != 0.
  - REQ: mem_req=1, mem_addr/mem_wdata = head entry, held stable until mem_ack. On mem_ack: pop head (head+1, count-1); stay REQ if count after pop and push ≠ 0, else IDLE.
- mem_ack sampled only in REQ; ack in IDLE ignored.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, push is refused even if a pop occurs the same cycle (commit_ready derives from registered count).
- Forwarding: combinational scan of occupied entries head..tail-1; youngest (closest to tail) match wins. Entry being popped this cycle still forwards. Entry being pushed this cycle is not visible until next cycle.
- No flush input: entries are committed and architecturally final.

## Timing
- Reset (async): count=0, head=tail=0, state=IDLE; mem_req=0, mem_addr=0, mem_wdata=0, commit_ready=1, empty=1, ld_hit=0, ld_data=0. Reset during REQ drops mem_req immediately; pending write abandoned.
- Push-to-request latency: push at edge N → state REQ after edge N+1 → mem_req high during cycle N+1..; i.e. one idle cycle minimum from empty.
- Back-to-back drain: ack at edge M with more entries → mem_req stays high, next entry presented after edge M; one store per cycle with single-cycle ack.
- count/empty/commit_ready registered, update one edge after push/pop.
- ld_hit/ld_data purely combinational from ld_addr and storage (same cycle).

## Structure
- Shared package: StoreEntry typedef {address, value}, matching existing inst width; state enum {SQ_IDLE, SQ_REQ}.
- One sub-module natural: store_fwd_match (combinational youngest-match priority scan over entries given head/count), parameterised on DEPTH.

## Test plan
- Push (0x004,11),(0x008,22),(0x00C,33); ack each 2 cycles after mem_req → memory sees writes in that order, empty=1 after third ack, mem_req=0.
- 8 pushes with mem_ack held 0 → count=8, commit_ready=0; 9th push (0x0FF,99) ignored; after one ack count=7, commit_ready=1 next cycle.
- Push (0x010,5) then (0x010,7); ld_addr=0x010 → ld_hit=1, ld_data=7; ld_addr=0x011 → ld_hit=0, ld_data=0.
- At count=4, assert push and mem_ack same edge → count stays 4, next mem_addr is second-oldest entry.
- Assert RSTN_N=0 mid-REQ with count=3 → mem_req=0 and count=0 immediately, no further writes after release.
- 20 pushes interleaved with single-cycle acks → pointers wrap twice, all 20 writes in order, no loss or duplication.

Source files
------------

// File: rtl/store_queue_pkg.sv
// store_queue_pkg: types shared by the committed-store buffer.
//   store_entry_t : one buffered store {addr, value} at the native word width
//   sq_state_e    : drain FSM state
package store_queue_pkg;
  localparam int SQ_ADDR_W = 10;
  localparam int SQ_DATA_W = 32;

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] value;
  } store_entry_t;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_REQ  = 1'b1
  } sq_state_e;
endpackage

// File: rtl/store_fwd_match.sv
// store_fwd_match: load-forwarding lookup over the store ring.
//   ent_addr/ent_data : ring storage, physical index order
//   head, count       : occupied window is head .. head+count-1 (mod DEPTH)
//   ld_addr           : lookup address
//   ld_hit/ld_data    : youngest occupied match; ld_data is 0 without a hit
module store_fwd_match
  import store_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = SQ_ADDR_W,
  parameter int DATA_W = SQ_DATA_W
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [$clog2(DEPTH):0]       count,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_hit,
  output logic [DATA_W-1:0]            ld_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest by age offset; a later match overrides an
  // earlier one, so the entry closest to tail wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (ent_addr[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = ent_data[idx];
      end
    end
  end
endmodule

// File: rtl/store_queue.sv
// store_queue: committed-store buffer between ROB commit and data memory.
//   commit_valid/addr/data, commit_ready : push side (ready = not full)
//   mem_req/addr/wdata, mem_ack          : one write in flight, held until ack
//   ld_addr, ld_hit/ld_data              : combinational store-to-load forward
//   count, empty                         : occupancy; empty gates CPU halt
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = SQ_ADDR_W,
  parameter int DATA_W = SQ_DATA_W
) (
  input  logic                     clk,
  input  logic                     RSTN_N,
  input  logic                     commit_valid,
  input  logic [ADDR_W-1:0]        commit_addr,
  input  logic [DATA_W-1:0]        commit_data,
  output logic                     commit_ready,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PW-1:0]                head, tail;
  logic [CW-1:0]                count_nxt;
  sq_state_e                    state;
  logic                         push, pop;

  // Ready comes from the registered count only, so a full queue refuses a
  // push even on a cycle that also pops.
  assign commit_ready = (count != CW'(DEPTH));
  assign empty        = (count == '0);
  assign push         = commit_valid && commit_ready;
  assign pop          = (state == SQ_REQ) && mem_ack;
  assign count_nxt    = count + CW'(push) - CW'(pop);

  assign mem_req   = (state == SQ_REQ);
  assign mem_addr  = mem_req ? ent_addr[head] : '0;
  assign mem_wdata = mem_req ? ent_data[head] : '0;

  // Storage needs no reset: nothing reads an entry outside the occupied window.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= commit_addr;
      ent_data[tail] <= commit_data;
    end
  end

  always_ff @(posedge clk or negedge RSTN_N) begin
    if (!RSTN_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count_nxt;
    end
  end

  // Drain FSM. Entering REQ only from a non-zero count guarantees REQ
  // always has a valid head to present.
  always_ff @(posedge clk or negedge RSTN_N) begin
    if (!RSTN_N) begin
      state <= SQ_IDLE;
    end else begin
      case (state)
        SQ_IDLE: if (count != '0) state <= SQ_REQ;
        SQ_REQ:  if (mem_ack && (count_nxt == '0)) state <= SQ_IDLE;
        default: state <= SQ_IDLE;
      endcase
    end
  end

  store_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .head     (head),
    .count    (count),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data)
  );
endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
  import store_queue_pkg::*;

  logic        clk = 1'b0;
  logic        RSTN_N = 1'b0;
  logic        commit_valid = 1'b0;
  logic [9:0]  commit_addr = '0;
  logic [31:0] commit_data = '0;
  logic        commit_ready;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic [3:0]  count;
  logic        empty;

  int n_chk = 0;
  int n_fail = 0;
  store_entry_t wlog[$];

  always #5 clk = ~clk;

  store_queue dut (
    .clk(clk), .RSTN_N(RSTN_N),
    .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_data(commit_data),
    .commit_ready(commit_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .count(count), .empty(empty)
  );

  // Called at a negedge: drives one cycle of stimulus, logs the write that
  // memory accepts at the coming posedge, returns at the next negedge.
  task automatic step(input bit pv, input logic [9:0] a, input logic [31:0] d, input bit ack);
    commit_valid = pv; commit_addr = a; commit_data = d; mem_ack = ack;
    if (ack && mem_req) wlog.push_back('{addr: mem_addr, value: mem_wdata});
    @(negedge clk);
    commit_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && !mem_req; k++) step(0, '0, '0, 0);
    n_chk++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req: mem_req=%b expected 1 within 20 cycles", mem_req); end
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    n_chk++; if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    n_chk++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rst_count: got %0d/%b expected 0/1", count, empty); end
    n_chk++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", commit_ready); end
    n_chk++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fail++; $display("FAIL rst_ld: got %b/%h expected 0/0", ld_hit, ld_data); end
    @(negedge clk); RSTN_N = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_order();
    logic [9:0]  ea[3] = '{10'h004, 10'h008, 10'h00C};
    logic [31:0] ed[3] = '{32'd11, 32'd22, 32'd33};
    wlog.delete();
    for (int i = 0; i < 3; i++) step(1, ea[i], ed[i], 0);
    for (int w = 0; w < 3; w++) begin
      wait_req();
      step(0, '0, '0, 0); step(0, '0, '0, 0); step(0, '0, '0, 1);
    end
    n_chk++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL basic_empty: got %b/%0d expected 1/0", empty, count); end
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_low: got %b expected 0", mem_req); end
    n_chk++;
    if (wlog.size() != 3) begin n_fail++; $display("FAIL basic_nwrites: got %0d expected 3", wlog.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (wlog[i].addr !== ea[i] || wlog[i].value !== ed[i]) begin
        n_fail++; $display("FAIL basic_write%0d: got %h/%0d expected %h/%0d", i, wlog[i].addr, wlog[i].value, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_full();
    wlog.delete();
    for (int i = 0; i < 8; i++) step(1, 10'(10'h100 + i), 32'(100 + i), 0);
    n_chk++; if (count !== 4'd8 || commit_ready !== 1'b0) begin n_fail++; $display("FAIL full_count: got %0d/%b expected 8/0", count, commit_ready); end
    step(1, 10'h0FF, 32'd99, 0);
    n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_refuse: got %0d expected 8", count); end
    step(0, '0, '0, 1);
    n_chk++; if (count !== 4'd7 || commit_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop: got %0d/%b expected 7/1", count, commit_ready); end
    for (int i = 0; i < 7; i++) step(0, '0, '0, 1);
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty: got %b expected 1", empty); end
    n_chk++;
    if (wlog.size() != 8) begin n_fail++; $display("FAIL full_nwrites: got %0d expected 8", wlog.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (wlog[i].addr !== 10'(10'h100 + i) || wlog[i].value !== 32'(100 + i)) begin
        n_fail++; $display("FAIL full_write%0d: got %h/%0d expected %h/%0d", i, wlog[i].addr, wlog[i].value, 10'h100 + i, 100 + i);
      end
    end
  endtask

  task automatic test_forward();
    wlog.delete();
    step(1, 10'h010, 32'd5, 0);
    step(1, 10'h010, 32'd7, 0);
    ld_addr = 10'h010; #1;
    n_chk++; if (ld_hit !== 1'b1 || ld_data !== 32'd7) begin n_fail++; $display("FAIL fwd_youngest: got %b/%0d expected 1/7", ld_hit, ld_data); end
    ld_addr = 10'h011; #1;
    n_chk++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin n_fail++; $display("FAIL fwd_miss: got %b/%0d expected 0/0", ld_hit, ld_data); end
    // a store being pushed this cycle must not forward until after the edge
    ld_addr = 10'h020; commit_valid = 1'b1; commit_addr = 10'h020; commit_data = 32'd9; #1;
    n_chk++; if (ld_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle_push: got %b expected 0", ld_hit); end
    @(negedge clk); commit_valid = 1'b0; #1;
    n_chk++; if (ld_hit !== 1'b1 || ld_data !== 32'd9) begin n_fail++; $display("FAIL fwd_after_push: got %b/%0d expected 1/9", ld_hit, ld_data); end
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1);
    n_chk++;
    if (wlog.size() != 3 || wlog[0].value !== 32'd5 || wlog[1].value !== 32'd7 || wlog[2].value !== 32'd9)
      begin n_fail++; $display("FAIL fwd_drain: got %0d writes expected 3 (5,7,9)", wlog.size()); end
    ld_addr = 10'h010; #1;
    n_chk++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin n_fail++; $display("FAIL fwd_after_drain: got %b/%0d expected 0/0", ld_hit, ld_data); end
    ld_addr = '0;
    @(negedge clk);
  endtask

  task automatic test_simul_push_pop();
    wlog.delete();
    for (int i = 0; i < 4; i++) step(1, 10'(10'h200 + i), 32'(200 + i), 0);
    n_chk++; if (count !== 4'd4 || mem_req !== 1'b1) begin n_fail++; $display("FAIL sim_setup: got %0d/%b expected 4/1", count, mem_req); end
    step(1, 10'h204, 32'd204, 1);
    n_chk++; if (count !== 4'd4) begin n_fail++; $display("FAIL sim_count: got %0d expected 4", count); end
    n_chk++; if (mem_addr !== 10'h201 || mem_wdata !== 32'd201) begin n_fail++; $display("FAIL sim_next_head: got %h/%0d expected 201/201", mem_addr, mem_wdata); end
    for (int i = 0; i < 4; i++) step(0, '0, '0, 1);
    n_chk++;
    if (wlog.size() != 5) begin n_fail++; $display("FAIL sim_nwrites: got %0d expected 5", wlog.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (wlog[i].addr !== 10'(10'h200 + i) || wlog[i].value !== 32'(200 + i)) begin
        n_fail++; $display("FAIL sim_write%0d: got %h/%0d expected %h/%0d", i, wlog[i].addr, wlog[i].value, 10'h200 + i, 200 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1, 10'(10'h300 + i), 32'(300 + i), 0);
    wait_req();
    n_chk++; if (count !== 4'd3) begin n_fail++; $display("FAIL rmid_setup: got %0d expected 3", count); end
    RSTN_N = 1'b0; #1;
    n_chk++; if (mem_req !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rmid_async: got req=%b count=%0d empty=%b expected 0/0/1", mem_req, count, empty); end
    @(negedge clk); RSTN_N = 1'b1;
    wlog.delete();
    for (int i = 0; i < 5; i++) step(0, '0, '0, 1);
    n_chk++; if (wlog.size() != 0 || mem_req !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL rmid_no_writes: got %0d writes req=%b count=%0d expected 0/0/0", wlog.size(), mem_req, count); end
  endtask

  task automatic test_back_to_back_wrap();
    wlog.delete();
    for (int i = 0; i < 20; i++) step(1, 10'(10'h400 + i), 32'(1000 + i), 1);
    for (int k = 0; k < 10 && !empty; k++) step(0, '0, '0, 1);
    n_chk++; if (empty !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b/%b expected 1/0", empty, mem_req); end
    n_chk++;
    if (wlog.size() != 20) begin n_fail++; $display("FAIL wrap_nwrites: got %0d expected 20", wlog.size()); end
    else for (int i = 0; i < 20; i++) begin
      n_chk++;
      if (wlog[i].addr !== 10'(10'h400 + i) || wlog[i].value !== 32'(1000 + i)) begin
        n_fail++; $display("FAIL wrap_write%0d: got %h/%0d expected %h/%0d", i, wlog[i].addr, wlog[i].value, 10'h400 + i, 1000 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_full();
    test_forward();
    test_simul_push_pop();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
